mac_datapath: RTL and testbench

- Arithmetic datapath that responds to the MAC sequencing controller's control strobes (init_w, init_x, load_a, load_sel).
- Stores a weight vector and an input vector, then computes one signed product per step through a registered multiply stage and a registered add stage.
- Writes the running sum back on load_a and reports isfinished to the controller once all N elements are accumulated.
- Sits between the operand sources and the controller; acc_out feeds the activation/output stage.

---
 rtl/mac_datapath.sv | 129 ++++++++++++
 tb/tb_mac_datapath.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_datapath.sv
// rtl/mac_datapath.sv - MAC datapath: vector storage, registered multiply/add stages, accumulator write-back (optional ACC_SAT_EN saturating accumulate)
module mac_datapath #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_w,
  input  logic                       init_x,
  input  logic                       load_a,
  input  logic                       load_sel,
  input  logic [N*DW-1:0]            w_in,
  input  logic [N*DW-1:0]            x_in,
  output logic                       isfinished,
  output logic signed [ACC_W-1:0]    acc_out,
  output logic [$clog2(N+1)-1:0]     idx_out
);

  localparam int IW = $clog2(N+1);
  localparam int PW = 2 * DW;

  // The guard bit above ACC_W is only observable by the saturating write-back;
  // when wrapping, the low ACC_W bits of the sum are all that matter.
`ifdef ACC_SAT_EN
  localparam int SUM_W = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`else
  localparam int SUM_W = ACC_W;
`endif

  logic signed [DW-1:0]    w_q [N];
  logic signed [DW-1:0]    w_d [N];
  logic signed [DW-1:0]    x_q [N];
  logic signed [DW-1:0]    x_d [N];
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [DW-1:0]    w_sel, x_sel;
  logic                    at_end;

  assign at_end = (idx_q == IW'(N));

  // Select the operand pair addressed by the current index (zero once idx reaches N)
  always_comb begin
    w_sel = '0;
    x_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        w_sel = w_q[i];
        x_sel = x_q[i];
      end
    end
  end

  // Multiply and add stage next values; both stages run every cycle
  always_comb begin
    prod_d = '0;
    if (!at_end) begin
      prod_d = PW'(w_sel) * PW'(x_sel);
    end
    sum_d = SUM_W'(acc_q) + SUM_W'(prod_q);
  end

  // Vector capture, index advance and accumulator write-back; init wins over load_a
  always_comb begin
    w_d   = w_q;
    x_d   = x_q;
    idx_d = idx_q;
    acc_d = acc_q;
    if (init_w || init_x) begin
      if (init_w) begin
        for (int i = 0; i < N; i++) begin
          w_d[i] = w_in[i*DW +: DW];
        end
      end
      if (init_x) begin
        for (int i = 0; i < N; i++) begin
          x_d[i] = x_in[i*DW +: DW];
        end
      end
      idx_d = '0;
      acc_d = '0;
    end else if (load_a && !at_end) begin
      if (load_sel) begin
        acc_d = ACC_W'(prod_q);
      end else begin
`ifdef ACC_SAT_EN
        if (sum_q[SUM_W-1] != sum_q[SUM_W-2]) begin
          acc_d = sum_q[SUM_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
          acc_d = sum_q[ACC_W-1:0];
        end
`else
        acc_d = sum_q;
`endif
      end
      idx_d = idx_q + IW'(1);
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
      idx_q  <= '0;
      acc_q  <= '0;
      prod_q <= '0;
      sum_q  <= '0;
    end else begin
      w_q    <= w_d;
      x_q    <= x_d;
      idx_q  <= idx_d;
      acc_q  <= acc_d;
      prod_q <= prod_d;
      sum_q  <= sum_d;
    end
  end

  assign isfinished = at_end;
  assign acc_out    = acc_q;
  assign idx_out    = idx_q;

endmodule

// File: tb/tb_mac_datapath.sv
// tb/tb_mac_datapath.sv - self-checking bench for mac_datapath (behavioural model, directed and random runs)
module tb_mac_datapath;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int ACC_W = 16;
  localparam int IW    = $clog2(N+1);
  localparam int MOD   = 1 << ACC_W;
  localparam int HALF  = 1 << (ACC_W-1);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    init_w = 1'b0;
  logic                    init_x = 1'b0;
  logic                    load_a = 1'b0;
  logic                    load_sel = 1'b0;
  logic [N*DW-1:0]         w_in = '0;
  logic [N*DW-1:0]         x_in = '0;
  logic                    isfinished;
  logic signed [ACC_W-1:0] acc_out;
  logic [IW-1:0]           idx_out;

  int checks = 0;
  int failures = 0;

  int m_w [N];
  int m_x [N];
  int m_idx = 0;
  int m_acc = 0;

  mac_datapath #(.N(N), .DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .init_w(init_w), .init_x(init_x),
    .load_a(load_a), .load_sel(load_sel), .w_in(w_in), .x_in(x_in),
    .isfinished(isfinished), .acc_out(acc_out), .idx_out(idx_out)
  );

  always #5 clk = ~clk;

  function automatic int elem(logic [N*DW-1:0] v, int i);
    logic signed [DW-1:0] e;
    e = v[i*DW +: DW];
    return int'(e);
  endfunction

  function automatic int accfit(int v);
    int r;
`ifdef ACC_SAT_EN
    if (v > HALF - 1) return HALF - 1;
    if (v < -HALF) return -HALF;
    return v;
`else
    r = v % MOD;
    if (r < 0) r += MOD;
    if (r >= HALF) r -= MOD;
    return r;
`endif
  endfunction

  function automatic logic [N*DW-1:0] pack(int a0, int a1, int a2, int a3);
    return {a3[DW-1:0], a2[DW-1:0], a1[DW-1:0], a0[DW-1:0]};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: dot-product semantics straight from the rules
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_w[i] <= 0;
        m_x[i] <= 0;
      end
      m_idx <= 0;
      m_acc <= 0;
    end else if (init_w || init_x) begin
      for (int i = 0; i < N; i++) begin
        if (init_w) m_w[i] <= elem(w_in, i);
        if (init_x) m_x[i] <= elem(x_in, i);
      end
      m_idx <= 0;
      m_acc <= 0;
    end else if (load_a && m_idx < N) begin
      m_acc <= load_sel ? m_w[m_idx] * m_x[m_idx]
                        : accfit(m_acc + m_w[m_idx] * m_x[m_idx]);
      m_idx <= m_idx + 1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("acc_out", int'(acc_out), m_acc);
      chk("idx_out", int'(idx_out), m_idx);
      chk("isfinished", int'(isfinished), int'(m_idx == N));
    end
  end

  // Drive one clock edge's worth of controls from a negedge, then release them
  task automatic step(bit iw, bit ix, bit la, bit ls, logic [N*DW-1:0] wv, logic [N*DW-1:0] xv);
    init_w = iw; init_x = ix; load_a = la; load_sel = ls;
    w_in = wv; x_in = xv;
    @(negedge clk);
    init_w = 1'b0; init_x = 1'b0; load_a = 1'b0; load_sel = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_init(logic [N*DW-1:0] wv, logic [N*DW-1:0] xv);
    step(1'b1, 1'b1, 1'b0, 1'b0, wv, xv);
  endtask

  task automatic do_load(bit ls, int gap);
    idle(gap);
    step(1'b0, 1'b0, 1'b1, ls, w_in, x_in);
  endtask

  task automatic load_expect(bit ls, int exp, string name);
    do_load(ls, 2);
    chk(name, int'(acc_out), exp);
  endtask

  int exp_basic [4] = '{5, 17, 38, 70};
  int exp_sign  [4] = '{-21, -31, -33, -29};
`ifdef ACC_SAT_EN
  int exp_ovf   [4] = '{16384, 32767, 32767, 32767};
`else
  int exp_ovf   [4] = '{16384, -32768, -16384, 0};
`endif

  initial begin
    #1;
    chk("reset_acc", int'(acc_out), 0);
    chk("reset_idx", int'(idx_out), 0);
    chk("reset_fin", int'(isfinished), 0);
    idle(2);
    rst = 1'b0;
    idle(1);

    do_init(pack(1, 2, 3, 4), pack(5, 6, 7, 8));
    for (int i = 0; i < 4; i++) load_expect(1'b0, exp_basic[i], "basic_acc");
    chk("basic_idx", int'(idx_out), 4);
    chk("basic_fin", int'(isfinished), 1);

    for (int i = 0; i < 2; i++) load_expect(i[0], 70, "overrun_acc");
    chk("overrun_idx", int'(idx_out), 4);
    chk("overrun_fin", int'(isfinished), 1);

    do_init(pack(-3, 2, -1, 4), pack(7, -5, 2, 1));
    chk("init_clear_acc", int'(acc_out), 0);
    chk("init_clear_fin", int'(isfinished), 0);
    for (int i = 0; i < 4; i++) load_expect(i == 0, exp_sign[i], "signed_acc");

    do_init(pack(-128, -128, -128, -128), pack(-128, -128, -128, -128));
    for (int i = 0; i < 4; i++) load_expect(1'b0, exp_ovf[i], "overflow_acc");

    do_init(pack(1, 2, 3, 4), pack(5, 6, 7, 8));
    load_expect(1'b0, 5, "midrun_acc");
    load_expect(1'b0, 17, "midrun_acc");
    #2 rst = 1'b1;
    #1;
    chk("async_rst_acc", int'(acc_out), 0);
    chk("async_rst_idx", int'(idx_out), 0);
    chk("async_rst_fin", int'(isfinished), 0);
    idle(1);
    rst = 1'b0;
    idle(1);
    do_init(pack(1, 2, 3, 4), pack(5, 6, 7, 8));
    load_expect(1'b0, 5, "after_rst_acc");
    idle(2);
    step(1'b1, 1'b0, 1'b1, 1'b0, pack(9, 9, 9, 9), x_in);
    chk("init_vs_load_acc", int'(acc_out), 0);
    chk("init_vs_load_idx", int'(idx_out), 0);
    load_expect(1'b0, 45, "new_w_acc");

    for (int r = 0; r < 60; r++) begin
      logic [N*DW-1:0] wv, xv;
      int which;
      wv = {$urandom, $urandom};
      xv = {$urandom, $urandom};
      which = $urandom_range(1, 3);
      step(which[0], which[1], 1'b0, 1'b0, wv, xv);
      for (int k = 0; k < int'($urandom_range(0, N + 2)); k++) begin
        do_load(1'($urandom_range(0, 1)), $urandom_range(2, 4));
      end
      if ((r % 7) == 3) begin
        idle(2);
        step(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      end
      idle($urandom_range(0, 2));
    end

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
